step_clock_controller: RTL and testbench
========================================

// Module: step_clock_controller
// PURPOSE
//  Generates the processor clock-enable for procesadorArm from the board's clk_select switch and raw clk_step button.
//  Free-run mode enables the core every cycle. Step mode turns one debounced button press into exactly one burst of
//  STEP_CYCLES enables (one instruction plus its pipeline stalls). This block drives the stepping inputs that the
//  processor receives, and keeps cycle/step counters for debug and benches.
// PARAMETERS
//  SYNC_STAGES      2   flops in each input synchronizer (>=2)
//  DEBOUNCE_CYCLES  4   consecutive stable synced cycles to accept a press or a release (>=1)
//  STEP_CYCLES      6   cpu_en cycles per step burst (1 instr + 5 stalls; >=1)
//  CNT_W            32  width of cycle_count
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous, active-low reset
//  clk_select   in   1      async switch; 0 = free-run, 1 = step mode
//  clk_step     in   1      async raw step button, active-high, may bounce
//  cpu_en       out  1      registered clock-enable to the processor
//  busy         out  1      1 while a press is being debounced or a burst is running
//  cycle_count  out  CNT_W  number of cycles with cpu_en=1 since reset
//  step_count   out  16     number of bursts started since reset
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; cpu_en=0, busy=0, counters=0, debounce counter=0.
//   Step and select synchronizers reset to 0 and 1 respectively (step mode is the safe default).
//  Sync: clk_step and clk_select each pass through SYNC_STAGES flops -> step_s, sel_s. All logic below uses only these.
//  Free-run (sel_s=0): FSM forced to IDLE, burst and debounce counters cleared.
//   cpu_en=1 on the next edge and every edge after. busy=0. Button activity ignored.
//  Step mode (sel_s=1) FSM:
//   IDLE: step_s=1 -> DEBOUNCE_PRESS (dcnt=1).
//   DEBOUNCE_PRESS: step_s=1 -> dcnt++. When dcnt reaches DEBOUNCE_CYCLES -> BURST (bcnt=0) and step_count++.
//    step_s=0 -> back to IDLE; glitch rejected, no enable.
//   BURST: cpu_en=1 each cycle, bcnt++. After STEP_CYCLES enables -> WAIT_RELEASE. step_s is ignored here.
//   WAIT_RELEASE: wait until step_s=0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE. A high sample restarts the count.
//  cpu_en is registered from the next state: high exactly during the STEP_CYCLES cycles of BURST, low in every other
//   step-mode state.
//  busy = (state==DEBOUNCE_PRESS || state==BURST).
//  Latency: first cpu_en high comes SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge that samples clk_step=1
//   (6 with defaults), provided the button stays high.
//  A held button gives one burst only. A new press during BURST or WAIT_RELEASE is ignored.
//  Mode change step->free-run mid-burst: burst abandoned, cpu_en=1 continuously from the edge after sel_s falls.
//   No leftover burst enables are added.
//  Mode change free-run->step: cpu_en=0 from the edge after sel_s rises.
//   If step_s=1 at that edge -> WAIT_RELEASE, so a held button never fires a burst.
//  cycle_count += 1 on every edge where cpu_en=1; wraps mod 2^CNT_W. step_count wraps mod 2^16.
//   Both counters keep their values across mode changes; only rst clears them.
//  rst asserted mid-burst: all outputs 0 at once (async). After release the FSM restarts in IDLE with a fresh
//   synchronizer.
// TESTING
//  1 rst 0->1, clk_select=0: cpu_en=1 from edge 3 onward (SYNC_STAGES+1). After 10 enabled cycles cycle_count=10.
//  2 clk_select=1, clk_step high 20 cycles: cpu_en high exactly 6 consecutive cycles, first one 6 edges after press.
//    step_count=1, cycle_count=6, busy low after the burst.
//  3 step mode, clk_step high 3 cycles then low, then bounce 1/0/1/0: cpu_en never asserts; step_count=0.
//  4 step mode, clk_step held 100 cycles, released 10, pressed 20: exactly two bursts.
//    12 enables total, step_count=2.
//  5 step mode, clk_select->0 after 3 burst enables: cpu_en stays 1 continuously from 3 edges later.
//    Back to step mode with the button held: no burst until release and a new press.
//  6 assert rst mid-burst, off clock edge: cpu_en, busy and counters go to 0 before the next edge.
//    After release, a new press gives a full 6-cycle burst.

Source files
------------

// File: rtl/step_clock_controller.sv
// Clock-enable generator for procesadorArm: free-run, or one debounced button press
// produces exactly one burst of STEP_CYCLES enables.
module step_clock_controller #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int STEP_CYCLES     = 6,
   parameter int CNT_W           = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_select,
   input  logic             clk_step,
   output logic             cpu_en,
   output logic             busy,
   output logic [CNT_W-1:0] cycle_count,
   output logic [15:0]      step_count
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int BW = $clog2(STEP_CYCLES + 1);
   localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BW-1:0] BURST_LAST = BW'(STEP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE_PRESS,
      BURST,
      WAIT_RELEASE
   } state_t;

   state_t                 state, state_n;
   logic [DW-1:0]          dcnt, dcnt_n;
   logic [BW-1:0]          bcnt, bcnt_n;
   logic                   cpu_en_n;
   logic                   start_burst;
   logic                   sel_d;
   logic [SYNC_STAGES-1:0] step_sync;
   logic [SYNC_STAGES-1:0] sel_sync;
   logic                   step_s;
   logic                   sel_s;

   // Select resets to 1 so the core stays halted until the switch is really seen low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_sync <= '0;
         sel_sync  <= '1;
      end else begin
         step_sync <= {step_sync[SYNC_STAGES-2:0], clk_step};
         sel_sync  <= {sel_sync[SYNC_STAGES-2:0], clk_select};
      end
   end

   assign step_s = step_sync[SYNC_STAGES-1];
   assign sel_s  = sel_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         dcnt        <= '0;
         bcnt        <= '0;
         cpu_en      <= 1'b0;
         sel_d       <= 1'b1;
         cycle_count <= '0;
         step_count  <= '0;
      end else begin
         state  <= state_n;
         dcnt   <= dcnt_n;
         bcnt   <= bcnt_n;
         cpu_en <= cpu_en_n;
         sel_d  <= sel_s;
         if (cpu_en) begin
            cycle_count <= cycle_count + CNT_W'(1);
         end
         if (start_burst) begin
            step_count <= step_count + 16'd1;
         end
      end
   end

   // Entering step mode with the button already down parks in WAIT_RELEASE so it cannot fire.
   always_comb begin
      state_n     = state;
      dcnt_n      = dcnt;
      bcnt_n      = bcnt;
      start_burst = 1'b0;
      if (!sel_s) begin
         state_n = IDLE;
         dcnt_n  = '0;
         bcnt_n  = '0;
      end else if (!sel_d) begin
         state_n = step_s ? WAIT_RELEASE : IDLE;
         dcnt_n  = '0;
         bcnt_n  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (step_s) begin
                  state_n = DEBOUNCE_PRESS;
                  dcnt_n  = DW'(1);
               end
            end
            DEBOUNCE_PRESS: begin
               if (!step_s) begin
                  state_n = IDLE;
                  dcnt_n  = '0;
               end else if (dcnt == DEB_MAX) begin
                  state_n     = BURST;
                  dcnt_n      = '0;
                  bcnt_n      = '0;
                  start_burst = 1'b1;
               end else begin
                  dcnt_n = dcnt + DW'(1);
               end
            end
            BURST: begin
               if (bcnt == BURST_LAST) begin
                  state_n = WAIT_RELEASE;
                  bcnt_n  = '0;
                  dcnt_n  = '0;
               end else begin
                  bcnt_n = bcnt + BW'(1);
               end
            end
            WAIT_RELEASE: begin
               if (step_s) begin
                  dcnt_n = '0;
               end else if (dcnt == DEB_LAST) begin
                  state_n = IDLE;
                  dcnt_n  = '0;
               end else begin
                  dcnt_n = dcnt + DW'(1);
               end
            end
            default: begin
               state_n = IDLE;
               dcnt_n  = '0;
               bcnt_n  = '0;
            end
         endcase
      end
   end

   assign cpu_en_n = !sel_s || (state_n == BURST);
   assign busy     = (state == DEBOUNCE_PRESS) || (state == BURST);

endmodule

// File: tb/tb_step_clock_controller.sv
// Bench for step_clock_controller: cycle-exact vector table after reset, then
// hand-written sequences for glitches, held buttons, mode changes and reset mid-burst.
module tb_step_clock_controller;

   logic        clk;
   logic        rst;
   logic        clk_select;
   logic        clk_step;
   logic        cpu_en;
   logic        busy;
   logic [31:0] cycle_count;
   logic [15:0] step_count;

   int tests;
   int fails;
   int en_seen;

   typedef struct {
      logic        sel;
      logic        step;
      int          n;
      logic        en;
      logic        busy;
      logic [31:0] cc;
      logic [15:0] sc;
   } vec_t;

   vec_t vecs[15];

   step_clock_controller dut (
      .clk         (clk),
      .rst         (rst),
      .clk_select  (clk_select),
      .clk_step    (clk_step),
      .cpu_en      (cpu_en),
      .busy        (busy),
      .cycle_count (cycle_count),
      .step_count  (step_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive inputs, advance n edges, sample #1 after each edge and tally enables.
   task automatic applyStimulus(input logic sel, input logic step, input int n);
      clk_select = sel;
      clk_step   = step;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (cpu_en) en_seen++;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      en_seen    = 0;
      rst        = 1'b0;
      clk_select = 1'b0;
      clk_step   = 1'b0;

      // Free-run start, then step mode and one held press of 20 cycles.
      vecs[0]  = '{1'b0, 1'b0, 1,  1'b0, 1'b0, 32'd0,  16'd0};
      vecs[1]  = '{1'b0, 1'b0, 1,  1'b0, 1'b0, 32'd0,  16'd0};
      vecs[2]  = '{1'b0, 1'b0, 1,  1'b1, 1'b0, 32'd0,  16'd0};
      vecs[3]  = '{1'b0, 1'b0, 10, 1'b1, 1'b0, 32'd10, 16'd0};
      vecs[4]  = '{1'b1, 1'b0, 2,  1'b1, 1'b0, 32'd12, 16'd0};
      vecs[5]  = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 32'd13, 16'd0};
      vecs[6]  = '{1'b1, 1'b0, 2,  1'b0, 1'b0, 32'd13, 16'd0};
      vecs[7]  = '{1'b1, 1'b1, 2,  1'b0, 1'b0, 32'd13, 16'd0};
      vecs[8]  = '{1'b1, 1'b1, 1,  1'b0, 1'b1, 32'd13, 16'd0};
      vecs[9]  = '{1'b1, 1'b1, 3,  1'b0, 1'b1, 32'd13, 16'd0};
      vecs[10] = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 32'd13, 16'd1};
      vecs[11] = '{1'b1, 1'b1, 5,  1'b1, 1'b1, 32'd18, 16'd1};
      vecs[12] = '{1'b1, 1'b1, 1,  1'b0, 1'b0, 32'd19, 16'd1};
      vecs[13] = '{1'b1, 1'b1, 8,  1'b0, 1'b0, 32'd19, 16'd1};
      vecs[14] = '{1'b1, 1'b0, 10, 1'b0, 1'b0, 32'd19, 16'd1};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset cpu_en", {31'd0, cpu_en}, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset cycle_count", cycle_count, 32'd0);
      checkOutput("reset step_count", {16'd0, step_count}, 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].sel, vecs[i].step, vecs[i].n);
         checkOutput($sformatf("vec%0d cpu_en", i), {31'd0, cpu_en}, {31'd0, vecs[i].en});
         checkOutput($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
         checkOutput($sformatf("vec%0d cycle_count", i), cycle_count, vecs[i].cc);
         checkOutput($sformatf("vec%0d step_count", i), {16'd0, step_count}, {16'd0, vecs[i].sc});
      end

      // Short press and bounces are rejected.
      en_seen = 0;
      applyStimulus(1'b1, 1'b1, 3);
      applyStimulus(1'b1, 1'b0, 10);
      applyStimulus(1'b1, 1'b1, 1);
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b1, 1'b1, 1);
      applyStimulus(1'b1, 1'b0, 10);
      checkOutput("glitch enables", en_seen, 0);
      checkOutput("glitch step_count", {16'd0, step_count}, 32'd1);
      checkOutput("glitch busy", {31'd0, busy}, 32'd0);

      // Long hold, release, second press: exactly two bursts.
      en_seen = 0;
      applyStimulus(1'b1, 1'b1, 100);
      applyStimulus(1'b1, 1'b0, 10);
      applyStimulus(1'b1, 1'b1, 20);
      applyStimulus(1'b1, 1'b0, 20);
      checkOutput("hold enables", en_seen, 12);
      checkOutput("hold step_count", {16'd0, step_count}, 32'd3);
      checkOutput("hold cycle_count", cycle_count, 32'd31);

      // Switch to free-run after three burst enables.
      en_seen = 0;
      applyStimulus(1'b1, 1'b1, 9);
      checkOutput("mid burst enables", en_seen, 3);
      checkOutput("mid burst cpu_en", {31'd0, cpu_en}, 32'd1);
      applyStimulus(1'b0, 1'b1, 3);
      en_seen = 0;
      applyStimulus(1'b0, 1'b1, 20);
      checkOutput("free-run enables", en_seen, 20);
      checkOutput("free-run busy", {31'd0, busy}, 32'd0);
      checkOutput("free-run step_count", {16'd0, step_count}, 32'd4);
      applyStimulus(1'b1, 1'b1, 3);
      checkOutput("back to step cpu_en", {31'd0, cpu_en}, 32'd0);
      checkOutput("back to step cycle_count", cycle_count, 32'd59);
      en_seen = 0;
      applyStimulus(1'b1, 1'b1, 30);
      checkOutput("held on entry enables", en_seen, 0);
      checkOutput("held on entry step_count", {16'd0, step_count}, 32'd4);
      applyStimulus(1'b1, 1'b0, 10);
      applyStimulus(1'b1, 1'b1, 20);
      applyStimulus(1'b1, 1'b0, 10);
      checkOutput("new press enables", en_seen, 6);
      checkOutput("new press step_count", {16'd0, step_count}, 32'd5);
      checkOutput("new press cycle_count", cycle_count, 32'd65);

      // Asynchronous reset in the middle of a burst.
      en_seen = 0;
      applyStimulus(1'b1, 1'b1, 8);
      checkOutput("pre-reset enables", en_seen, 2);
      checkOutput("pre-reset busy", {31'd0, busy}, 32'd1);
      #3;
      rst      = 1'b0;
      clk_step = 1'b0;
      #1;
      checkOutput("async reset cpu_en", {31'd0, cpu_en}, 32'd0);
      checkOutput("async reset busy", {31'd0, busy}, 32'd0);
      checkOutput("async reset cycle_count", cycle_count, 32'd0);
      checkOutput("async reset step_count", {16'd0, step_count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 5);
      checkOutput("post-reset cpu_en", {31'd0, cpu_en}, 32'd0);
      en_seen = 0;
      applyStimulus(1'b1, 1'b1, 6);
      checkOutput("latency no early enable", en_seen, 0);
      applyStimulus(1'b1, 1'b1, 1);
      checkOutput("latency first enable", {31'd0, cpu_en}, 32'd1);
      applyStimulus(1'b1, 1'b1, 12);
      applyStimulus(1'b1, 1'b0, 10);
      checkOutput("post-reset burst enables", en_seen, 6);
      checkOutput("post-reset step_count", {16'd0, step_count}, 32'd1);
      checkOutput("post-reset cycle_count", cycle_count, 32'd6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
